// File: rtl/contrast_stats_param.sv
// contrast_stats_param: per-frame min/max tracker with optional IIR smoothing
// and a sequential restoring divider producing a fixed-point contrast gain.
// Ports:
//   CLK100, RESET_N            clock, synchronous active-low reset
//   ENABLE                     0 freezes every register and ignores inputs
//   MODE                       0 instant, 1 smoothed, 2 freeze, 3 manual
//   MAN_MIN, MAN_MAX           manual range used in MODE 3
//   FRAME_START, FRAME_END     frame delimiters (1-cycle pulses)
//   PIX_VALID, PIX_DATA        pixel stream
//   MIN, MAX, GAIN             published statistics (GAIN is Q.GAIN_FRAC)
//   STATS_VALID                1-cycle pulse when MIN/MAX/GAIN are refreshed
//   BUSY                       high while a frame result is being computed
//   OVERRUN                    1-cycle pulse when a FRAME_END is dropped
module contrast_stats_param #(
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned GAIN_FRAC = 8,
    parameter int unsigned GAIN_W    = 16,
    parameter int unsigned SMOOTH_SH = 2,
    parameter int unsigned MIN_RANGE = 16
) (
    input  logic              CLK100,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] MAN_MIN,
    input  logic [DATA_W-1:0] MAN_MAX,
    input  logic              FRAME_START,
    input  logic              FRAME_END,
    input  logic              PIX_VALID,
    input  logic [DATA_W-1:0] PIX_DATA,
    output logic [DATA_W-1:0] MIN,
    output logic [DATA_W-1:0] MAX,
    output logic [GAIN_W-1:0] GAIN,
    output logic              STATS_VALID,
    output logic              BUSY,
    output logic              OVERRUN
);

    localparam int unsigned NUM_W  = OUT_W + GAIN_FRAC;
    localparam int unsigned CNT_W  = $clog2(NUM_W + 1);
    localparam int unsigned SW     = DATA_W + 1;
    localparam int unsigned WIDE_W = NUM_W + GAIN_W;

    localparam logic [NUM_W-1:0]  NUM_INIT = NUM_W'((2 ** OUT_W) - 1) << GAIN_FRAC;
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1) << GAIN_FRAC;
    localparam logic [DATA_W-1:0] ALL_ONES = '1;
    localparam logic [DATA_W-1:0] MIN_DIV  = DATA_W'(MIN_RANGE);

    typedef enum logic [1:0] {IDLE, SMOOTH, DIVIDE, DONE} state_t;

    state_t              state;
    logic                in_frame, seen;
    logic [DATA_W-1:0]   acc_min, acc_max;
    logic [DATA_W-1:0]   snap_min, snap_max;
    logic                snap_seen;
    logic                first_frame;
    logic [DATA_W-1:0]   sm_lo, sm_hi;
    logic [DATA_W-1:0]   tgt_lo, tgt_hi;
    logic                hold;
    logic [DATA_W-1:0]   div_q, rem;
    logic [NUM_W-1:0]    num_sh, quot;
    logic [CNT_W-1:0]    cnt;

    logic                pix_upd;
    logic [DATA_W-1:0]   fold_min, fold_max;
    logic                fold_seen;
    logic signed [SW-1:0] d_lo, d_hi;
    logic [DATA_W-1:0]   smooth_lo, smooth_hi;
    logic [DATA_W-1:0]   sel_lo, sel_hi;
    logic [SW-1:0]       range_c;
    logic [DATA_W-1:0]   divisor_c;
    logic [SW-1:0]       trial;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_nx;
    logic [GAIN_W-1:0]   gain_c;

    // Accumulator state with the current pixel folded in (covers FRAME_END pixel)
    always_comb begin
        pix_upd   = in_frame & PIX_VALID;
        fold_min  = acc_min;
        fold_max  = acc_max;
        fold_seen = seen | pix_upd;
        if (pix_upd) begin
            if (PIX_DATA < acc_min) fold_min = PIX_DATA;
            if (PIX_DATA > acc_max) fold_max = PIX_DATA;
        end
    end

    // IIR step: state += (snapshot - state) >>> SMOOTH_SH, signed arithmetic
    always_comb begin
        d_lo      = $signed({1'b0, snap_min}) - $signed({1'b0, sm_lo});
        d_hi      = $signed({1'b0, snap_max}) - $signed({1'b0, sm_hi});
        smooth_lo = DATA_W'($signed({1'b0, sm_lo}) + (d_lo >>> SMOOTH_SH));
        smooth_hi = DATA_W'($signed({1'b0, sm_hi}) + (d_hi >>> SMOOTH_SH));
    end

    // Target range selection and clamped divisor
    always_comb begin
        sel_lo = snap_min;
        sel_hi = snap_max;
        case (MODE)
            2'd1: begin
                if (!first_frame) begin
                    sel_lo = smooth_lo;
                    sel_hi = smooth_hi;
                end
            end
            2'd3: begin
                sel_lo = (MAN_MIN > MAN_MAX) ? MAN_MAX : MAN_MIN;
                sel_hi = (MAN_MIN > MAN_MAX) ? MAN_MIN : MAN_MAX;
            end
            default: ;
        endcase
        range_c   = {1'b0, sel_hi} - {1'b0, sel_lo};
        divisor_c = range_c[DATA_W-1:0];
        if (range_c[SW-1] || (range_c[DATA_W-1:0] < MIN_DIV)) divisor_c = MIN_DIV;
    end

    // One restoring-division step and the saturated quotient
    always_comb begin
        trial  = {rem, num_sh[NUM_W-1]};
        q_bit  = (trial >= {1'b0, div_q});
        rem_nx = q_bit ? DATA_W'(trial - {1'b0, div_q}) : DATA_W'(trial);
        gain_c = GAIN_W'(quot);
        if (WIDE_W'(quot) > WIDE_W'({GAIN_W{1'b1}})) gain_c = '1;
    end

    // Accumulator, frame FSM, divider and output registers
    always_ff @(posedge CLK100) begin
        if (!RESET_N) begin
            state       <= IDLE;
            in_frame    <= 1'b0;
            seen        <= 1'b0;
            acc_min     <= ALL_ONES;
            acc_max     <= '0;
            snap_min    <= '0;
            snap_max    <= '0;
            snap_seen   <= 1'b0;
            first_frame <= 1'b1;
            sm_lo       <= '0;
            sm_hi       <= '0;
            tgt_lo      <= '0;
            tgt_hi      <= '0;
            hold        <= 1'b0;
            div_q       <= MIN_DIV;
            rem         <= '0;
            num_sh      <= '0;
            quot        <= '0;
            cnt         <= '0;
            MIN         <= '0;
            MAX         <= ALL_ONES;
            GAIN        <= GAIN_ONE;
            STATS_VALID <= 1'b0;
            BUSY        <= 1'b0;
            OVERRUN     <= 1'b0;
        end else if (!ENABLE) begin
            STATS_VALID <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            STATS_VALID <= 1'b0;
            OVERRUN     <= 1'b0;

            if (FRAME_START) begin
                in_frame <= 1'b1;
                seen     <= PIX_VALID;
                acc_min  <= PIX_VALID ? PIX_DATA : ALL_ONES;
                acc_max  <= PIX_VALID ? PIX_DATA : '0;
            end else if (FRAME_END) begin
                in_frame <= 1'b0;
            end else if (pix_upd) begin
                seen    <= 1'b1;
                acc_min <= fold_min;
                acc_max <= fold_max;
            end

            case (state)
                IDLE: begin
                    if (FRAME_END && in_frame) begin
                        snap_min  <= fold_min;
                        snap_max  <= fold_max;
                        snap_seen <= fold_seen;
                        BUSY      <= 1'b1;
                        state     <= SMOOTH;
                    end
                end
                SMOOTH: begin
                    if (FRAME_END) OVERRUN <= 1'b1;
                    if ((MODE == 2'd2) || !snap_seen) begin
                        hold  <= 1'b1;
                        state <= DONE;
                    end else begin
                        hold   <= 1'b0;
                        tgt_lo <= sel_lo;
                        tgt_hi <= sel_hi;
                        div_q  <= divisor_c;
                        rem    <= '0;
                        num_sh <= NUM_INIT;
                        quot   <= '0;
                        cnt    <= '0;
                        if (MODE == 2'd1) begin
                            sm_lo       <= sel_lo;
                            sm_hi       <= sel_hi;
                            first_frame <= 1'b0;
                        end
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (FRAME_END) OVERRUN <= 1'b1;
                    rem    <= rem_nx;
                    quot   <= {quot[NUM_W-2:0], q_bit};
                    num_sh <= num_sh << 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_W - 1)) state <= DONE;
                end
                DONE: begin
                    if (FRAME_END) OVERRUN <= 1'b1;
                    if (!hold) begin
                        MIN  <= tgt_lo;
                        MAX  <= tgt_hi;
                        GAIN <= gain_c;
                    end
                    STATS_VALID <= 1'b1;
                    BUSY        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_contrast_stats_param.sv
// Self-checking bench for contrast_stats_param: table of frames plus
// hand-written sequences for overrun, reset mid-divide, coincident pixels
// and ENABLE=0. Expected results are queued when a frame is driven and
// compared by a monitor whenever STATS_VALID is seen.
module tb_contrast_stats_param;

    localparam int unsigned DATA_W = 14;
    localparam int unsigned GAIN_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b1;
    logic [1:0]        mode = '0;
    logic [DATA_W-1:0] man_min = '0, man_max = '0;
    logic              frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
    logic [DATA_W-1:0] pix_data = '0;
    logic [DATA_W-1:0] min_o, max_o;
    logic [GAIN_W-1:0] gain_o;
    logic              stats_valid, busy, overrun;

    contrast_stats_param dut (
        .CLK100(clk), .RESET_N(rst_n), .ENABLE(enable), .MODE(mode),
        .MAN_MIN(man_min), .MAN_MAX(man_max),
        .FRAME_START(frame_start), .FRAME_END(frame_end),
        .PIX_VALID(pix_valid), .PIX_DATA(pix_data),
        .MIN(min_o), .MAX(max_o), .GAIN(gain_o),
        .STATS_VALID(stats_valid), .BUSY(busy), .OVERRUN(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int mx;
        int gain;
    } exp_t;

    typedef struct {
        int rst;
        int mode;
        int man_min;
        int man_max;
        int npix;
        int pmin;
        int pmax;
        int e_min;
        int e_max;
        int e_gain;
        int e_lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every STATS_VALID consumes one expected result
    always @(negedge clk) begin
        if (stats_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stats_valid: MIN=%0d MAX=%0d GAIN=%0d",
                         min_o, max_o, gain_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_min", int'(min_o), e.mn);
                chk("sb_max", int'(max_o), e.mx);
                chk("sb_gain", int'(gain_o), e.gain);
            end
        end
    end

    task automatic push_exp(input int mn, input int mx, input int gain);
        exp_t e;
        e.mn = mn;
        e.mx = mx;
        e.gain = gain;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_start = 1'b0;
        frame_end = 1'b0;
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives a frame; FRAME_END is left asserted for the next edge (edge N).
    // start_val/end_val >= 0 put a pixel on the FRAME_START/FRAME_END cycle.
    task automatic run_frame(input int md, input int mmin, input int mmax,
                             input int npix, input int pmin, input int pmax,
                             input int start_val, input int end_val);
        @(negedge clk);
        mode = 2'(md);
        man_min = DATA_W'(mmin);
        man_max = DATA_W'(mmax);
        frame_start = 1'b1;
        pix_valid = (start_val >= 0);
        pix_data = DATA_W'((start_val >= 0) ? start_val : 0);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            pix_valid = 1'b1;
            if (i == 0) pix_data = DATA_W'(pmin);
            else if (i == npix - 1) pix_data = DATA_W'(pmax);
            else pix_data = DATA_W'($urandom_range(pmax, pmin));
        end
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid = (end_val >= 0);
        pix_data = DATA_W'((end_val >= 0) ? end_val : 0);
        frame_end = 1'b1;
    endtask

    // Latency counts edges after the FRAME_END edge N; a pulse set at edge
    // N+k is first sampled high by a flop at edge N+k+1.
    task automatic wait_stats(input string name, input int exp_lat);
        int lat;
        lat = -1;
        @(negedge clk);
        frame_end = 1'b0;
        pix_valid = 1'b0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (stats_valid) lat = c + 1;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no STATS_VALID, expected latency %0d", name, exp_lat);
        end else begin
            chk({name, "_latency"}, lat, exp_lat);
            @(negedge clk);
            chk({name, "_pulse_width"}, int'(stats_valid), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected simulation end");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv_cnt, ovr_cnt, lat;

        vecs[0] = '{1, 0, 0, 0, 100, 2000, 3000, 2000, 3000, 65, 19};
        vecs[1] = '{0, 0, 0, 0, 20, 5000, 5000, 5000, 5000, 4080, 19};
        vecs[2] = '{0, 3, 9000, 1000, 10, 100, 200, 1000, 9000, 8, 19};
        vecs[3] = '{0, 2, 0, 0, 10, 50, 60, 1000, 9000, 8, 3};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 1000, 9000, 8, 3};
        vecs[5] = '{1, 1, 0, 0, 50, 0, 1000, 0, 1000, 65, 19};
        vecs[6] = '{0, 1, 0, 0, 50, 400, 1400, 100, 1100, 65, 19};
        vecs[7] = '{0, 0, 0, 0, 30, 0, 4000, 0, 4000, 16, 19};
        vecs[8] = '{0, 1, 0, 0, 30, 400, 1400, 175, 1175, 65, 19};
        vecs[9] = '{0, 1, 0, 0, 30, 0, 100, 131, 906, 84, 19};

        do_reset();
        @(negedge clk);
        chk("rst_min", int'(min_o), 0);
        chk("rst_max", int'(max_o), 16383);
        chk("rst_gain", int'(gain_o), 256);
        chk("rst_stats_valid", int'(stats_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst != 0) do_reset();
            push_exp(vecs[i].e_min, vecs[i].e_max, vecs[i].e_gain);
            run_frame(vecs[i].mode, vecs[i].man_min, vecs[i].man_max,
                      vecs[i].npix, vecs[i].pmin, vecs[i].pmax, -1, -1);
            wait_stats($sformatf("vec%0d", i), vecs[i].e_lat);
        end

        // ENABLE=0: frame pulses ignored, outputs frozen
        @(negedge clk);
        enable = 1'b0;
        run_frame(0, 0, 0, 10, 3000, 4000, -1, -1);
        sv_cnt = 0;
        ovr_cnt = 0;
        @(negedge clk);
        frame_end = 1'b0;
        pix_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (stats_valid) sv_cnt++;
            if (busy) ovr_cnt++;
        end
        chk("dis_stats_count", sv_cnt, 0);
        chk("dis_busy_cycles", ovr_cnt, 0);
        chk("dis_min_held", int'(min_o), 131);
        enable = 1'b1;

        // Pixels on the FRAME_START and FRAME_END cycles are included
        do_reset();
        push_exp(10, 16000, 4);
        run_frame(0, 0, 0, 20, 100, 200, 10, 16000);
        wait_stats("coincident", 19);

        // Second FRAME_END while busy: one OVERRUN, one STATS_VALID
        push_exp(2000, 3000, 65);
        run_frame(0, 0, 0, 40, 2000, 3000, -1, -1);
        @(negedge clk);
        frame_end = 1'b0;
        pix_valid = 1'b0;
        sv_cnt = 0;
        ovr_cnt = 0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) chk("ovr_busy_high", int'(busy), 1);
            if (overrun) begin
                ovr_cnt++;
                chk("ovr_overrun_cycle", c, 5);
            end
            if (stats_valid) begin
                sv_cnt++;
                lat = c + 1;
            end
            frame_end = (c == 4);
        end
        chk("ovr_overrun_count", ovr_cnt, 1);
        chk("ovr_stats_count", sv_cnt, 1);
        chk("ovr_latency", lat, 19);

        // Reset during divide cycle 8: no STATS_VALID, outputs back to reset
        run_frame(0, 0, 0, 20, 500, 700, -1, -1);
        @(negedge clk);
        frame_end = 1'b0;
        pix_valid = 1'b0;
        sv_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (stats_valid) sv_cnt++;
            if (c == 8) begin
                chk("mid_busy_before_reset", int'(busy), 1);
                rst_n = 1'b0;
            end
            if (c == 9) begin
                rst_n = 1'b1;
                chk("mid_rst_min", int'(min_o), 0);
                chk("mid_rst_max", int'(max_o), 16383);
                chk("mid_rst_gain", int'(gain_o), 256);
                chk("mid_rst_busy", int'(busy), 0);
            end
        end
        chk("mid_stats_count", sv_cnt, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
